// File: rtl/motor_sequencer_if.sv
// Signal bundle between the motor sequencer and its surroundings:
// the encoder reader, the PI control loop and the PWM generator.
interface motor_sequencer_if;
  logic        start;
  logic        stop;
  logic        clear_fault;
  logic [31:0] target_period;
  logic [31:0] period;
  logic [9:0]  loop_duty;
  logic [9:0]  duty_out;
  logic [31:0] desired_period;
  logic        loop_reset;
  logic [2:0]  state;
  logic        fault;

  modport master (
    output start, stop, clear_fault, target_period, period, loop_duty,
    input  duty_out, desired_period, loop_reset, state, fault
  );

  modport slave (
    input  start, stop, clear_fault, target_period, period, loop_duty,
    output duty_out, desired_period, loop_reset, state, fault
  );
endinterface

// File: rtl/motor_sequencer.sv
// Motor start-up and supervision controller.
// Kicks the rotor open-loop, ramps the PI setpoint down to the commanded
// target, then holds closed-loop operation while watching for a stall.
//
// state | meaning
// IDLE  | motor off, PI loop held in reset
// KICK  | fixed open-loop duty for a fixed number of cycles
// RAMP  | closed loop, setpoint stepping down toward target_period
// RUN   | closed loop, setpoint follows target_period
// FAULT | latched failed-start or stall, waits for clear_fault
module motor_sequencer #(
  parameter logic [9:0]  KICK_DUTY     = 10'd512,
  parameter logic [31:0] KICK_CYCLES   = 32'd5_000_000,
  parameter logic [31:0] START_PERIOD  = 32'd200_000,
  parameter logic [31:0] RAMP_STEP     = 32'd1_000,
  parameter logic [31:0] RAMP_INTERVAL = 32'd50_000,
  parameter logic [31:0] STALL_PERIOD  = 32'd1_000_000,
  parameter logic [31:0] STALL_CYCLES  = 32'd10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  motor_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KICK  = 3'd1,
    RAMP  = 3'd2,
    RUN   = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [31:0] PARKED_PERIOD = 32'h7FFF_FFFF;

  state_t      state_q, state_d;
  logic [31:0] desired_q, desired_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] stall_q, stall_d;

  logic closed_loop;
  logic stalled;
  logic stall_hit;

  assign closed_loop = (state_q == RAMP) || (state_q == RUN);
  assign stalled     = closed_loop && (bus.period > STALL_PERIOD);
  // Fires on the cycle that would make the count reach STALL_CYCLES.
  assign stall_hit   = stalled && (stall_q >= (STALL_CYCLES - 32'd1));

  // Register state, setpoint and the shared kick/ramp timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      desired_q <= PARKED_PERIOD;
      timer_q   <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      desired_q <= desired_d;
      timer_q   <= timer_d;
      stall_q   <= stall_d;
    end
  end

  // Next-state, setpoint and timer logic; stop beats faults beats normal flow.
  always_comb begin
    state_d   = state_q;
    desired_d = desired_q;
    timer_d   = timer_q;
    stall_d   = 32'd0;

    if (stalled) begin
      stall_d = (stall_q >= STALL_CYCLES) ? stall_q : stall_q + 32'd1;
    end

    unique case (state_q)
      IDLE: begin
        desired_d = PARKED_PERIOD;
        timer_d   = 32'd0;
        if (bus.start && !bus.stop) begin
          state_d = KICK;
          timer_d = KICK_CYCLES - 32'd1;
        end
      end

      KICK: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (timer_q == 32'd0) begin
          if (bus.period < START_PERIOD) begin
            state_d   = RAMP;
            desired_d = START_PERIOD;
            timer_d   = RAMP_INTERVAL - 32'd1;
          end else begin
            state_d = FAULT;
          end
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      RAMP: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (stall_hit) begin
          state_d = FAULT;
        end else if (desired_q == bus.target_period) begin
          state_d = RUN;
        end else if (timer_q == 32'd0) begin
          timer_d = RAMP_INTERVAL - 32'd1;
          // Subtract only when the gap exceeds a step, so no underflow.
          if (desired_q <= bus.target_period) begin
            desired_d = bus.target_period;
          end else if ((desired_q - bus.target_period) > RAMP_STEP) begin
            desired_d = desired_q - RAMP_STEP;
          end else begin
            desired_d = bus.target_period;
          end
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (stall_hit) begin
          state_d = FAULT;
        end else begin
          desired_d = bus.target_period;
        end
      end

      FAULT: begin
        desired_d = PARKED_PERIOD;
        timer_d   = 32'd0;
        if (bus.clear_fault) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Leaving the active states parks the setpoint and clears all timers,
    // so nothing stale carries into the next start attempt.
    if ((state_d == IDLE) || (state_d == FAULT)) begin
      desired_d = PARKED_PERIOD;
      timer_d   = 32'd0;
    end
    if (!((state_d == RAMP) || (state_d == RUN))) begin
      stall_d = 32'd0;
    end
  end

  // Outputs decoded from the registered state; loop_duty passes straight through.
  always_comb begin
    bus.duty_out = 10'd0;
    if (closed_loop) begin
      bus.duty_out = bus.loop_duty;
    end else if (state_q == KICK) begin
      bus.duty_out = KICK_DUTY;
    end
  end

  assign bus.loop_reset     = !closed_loop;
  assign bus.fault          = (state_q == FAULT);
  assign bus.state          = state_q;
  assign bus.desired_period = desired_q;

endmodule

// File: tb/tb_motor_sequencer.sv
module tb_motor_sequencer;

  localparam logic [31:0] M = 32'h7FFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  motor_sequencer_if bus();

  motor_sequencer #(
    .KICK_DUTY    (10'd300),
    .KICK_CYCLES  (32'd16),
    .START_PERIOD (32'd1000),
    .RAMP_STEP    (32'd100),
    .RAMP_INTERVAL(32'd4),
    .STALL_PERIOD (32'd5000),
    .STALL_CYCLES (32'd8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        st;
    logic        sp;
    logic        cf;
    logic [31:0] tgt;
    logic [31:0] per;
    logic [9:0]  ld;
    int          n;
    logic [2:0]  es;
    logic [9:0]  ed;
    logic [31:0] edes;
    logic        elr;
    logic        ef;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, input logic sp, input logic cf,
                     input logic [31:0] tgt, input logic [31:0] per,
                     input logic [9:0] ld, input int n, input logic [2:0] es,
                     input logic [9:0] ed, input logic [31:0] edes,
                     input logic elr, input logic ef);
    vec_t v;
    v.st = st; v.sp = sp; v.cf = cf; v.tgt = tgt; v.per = per; v.ld = ld;
    v.n = n; v.es = es; v.ed = ed; v.edes = edes; v.elr = elr; v.ef = ef;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [2:0] es, input logic [9:0] ed,
                         input logic [31:0] edes, input logic elr, input logic ef);
    chk({nm, ".state"},   32'(bus.state),      32'(es));
    chk({nm, ".duty"},    32'(bus.duty_out),   32'(ed));
    chk({nm, ".desired"}, bus.desired_period,  edes);
    chk({nm, ".lreset"},  32'(bus.loop_reset), 32'(elr));
    chk({nm, ".fault"},   32'(bus.fault),      32'(ef));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int k = 0;
    while (bus.state !== s && k < 100) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(bus.state), 32'(s));
  endtask

  task automatic wait_des(input logic [31:0] v, input string nm);
    int k = 0;
    while (bus.desired_period !== v && k < 100) begin
      tick(1);
      k++;
    end
    chk(nm, bus.desired_period, v);
  endtask

  initial begin
    // Normal start: target 600, period 800
    add(1,0,0, 600, 800, 123,  1, 1, 300, M,    1, 0);
    add(0,0,0, 600, 800, 123, 14, 1, 300, M,    1, 0);
    add(0,0,0, 600, 800, 123,  1, 1, 300, M,    1, 0);
    add(0,0,0, 600, 800, 123,  1, 2, 123, 1000, 0, 0);
    add(0,0,0, 600, 800, 123,  3, 2, 123, 1000, 0, 0);
    add(0,0,0, 600, 800, 123,  1, 2, 123, 900,  0, 0);
    add(0,0,0, 600, 800, 123,  4, 2, 123, 800,  0, 0);
    add(0,0,0, 600, 800, 123,  4, 2, 123, 700,  0, 0);
    add(0,0,0, 600, 800, 123,  4, 2, 123, 600,  0, 0);
    add(0,0,0, 600, 800, 123,  1, 3, 123, 600,  0, 0);
    add(0,0,0, 600, 800, 456,  0, 3, 456, 600,  0, 0);
    add(0,1,0, 600, 800, 456,  1, 0, 0,   M,    1, 0);
    // Clamp: target 650, then retarget to 620 in RUN
    add(1,0,0, 650, 800, 456,  1, 1, 300, M,    1, 0);
    add(0,0,0, 650, 800, 456, 15, 1, 300, M,    1, 0);
    add(0,0,0, 650, 800, 456,  1, 2, 456, 1000, 0, 0);
    add(0,0,0, 650, 800, 456,  4, 2, 456, 900,  0, 0);
    add(0,0,0, 650, 800, 456,  4, 2, 456, 800,  0, 0);
    add(0,0,0, 650, 800, 456,  4, 2, 456, 700,  0, 0);
    add(0,0,0, 650, 800, 456,  4, 2, 456, 650,  0, 0);
    add(0,0,0, 650, 800, 456,  1, 3, 456, 650,  0, 0);
    add(0,0,0, 620, 800, 456,  0, 3, 456, 650,  0, 0);
    add(0,0,0, 620, 800, 456,  1, 3, 456, 620,  0, 0);
    // Failed start, start/stop ignored in FAULT, clear then restart
    add(0,1,0, 620, 800,  456,  1, 0, 0,   M,    1, 0);
    add(1,0,0, 620, 2000, 456,  1, 1, 300, M,    1, 0);
    add(1,0,0, 620, 2000, 456, 15, 1, 300, M,    1, 0);
    add(1,0,0, 620, 2000, 456,  1, 4, 0,   M,    1, 1);
    add(1,1,0, 620, 2000, 456,  3, 4, 0,   M,    1, 1);
    add(1,0,1, 620, 2000, 456,  1, 0, 0,   M,    1, 0);
    add(1,0,0, 620, 2000, 456,  1, 1, 300, M,    1, 0);
    add(0,1,0, 620, 2000, 456,  1, 0, 0,   M,    1, 0);

    bus.start = 0; bus.stop = 0; bus.clear_fault = 0;
    bus.target_period = 600; bus.period = 800; bus.loop_duty = 10'd123;
    reset = 1'b1;
    #12 reset = 1'b0;
    #1 chk_all("reset", 0, 0, M, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      bus.start = vq[i].st; bus.stop = vq[i].sp; bus.clear_fault = vq[i].cf;
      bus.target_period = vq[i].tgt; bus.period = vq[i].per; bus.loop_duty = vq[i].ld;
      tick(vq[i].n);
      chk_all($sformatf("vec%0d", i), vq[i].es, vq[i].ed, vq[i].edes, vq[i].elr, vq[i].ef);
    end

    // Stall in RUN: 7 stalled, 1 good, then 8 stalled faults
    bus.stop = 0; bus.clear_fault = 0; bus.target_period = 600;
    bus.period = 800; bus.loop_duty = 10'd77;
    bus.start = 1; tick(1); bus.start = 0;
    wait_state(3, "stall.reach_run");
    bus.period = 6000; tick(7);
    chk("stall.after7", 32'(bus.state), 32'd3);
    bus.period = 4000; tick(1);
    chk("stall.good_cycle", 32'(bus.state), 32'd3);
    bus.period = 6000; tick(7);
    chk("stall.after7_again", 32'(bus.state), 32'd3);
    tick(1);
    chk_all("stall.fault", 4, 0, M, 1, 1);
    bus.period = 800; bus.clear_fault = 1; tick(1);
    chk("stall.cleared", 32'(bus.state), 32'd0);
    bus.clear_fault = 0;

    // stop during KICK at cycle 5 with start held
    bus.start = 1; tick(1);
    tick(4);
    chk_all("kstop.kick5", 1, 300, M, 1, 0);
    bus.stop = 1; tick(1);
    chk_all("kstop.idle", 0, 0, M, 1, 0);
    bus.start = 0; bus.stop = 0; tick(1);

    // Async reset in the middle of RAMP
    bus.target_period = 600; bus.period = 800;
    bus.start = 1; tick(1); bus.start = 0;
    wait_des(800, "rst.reach800");
    chk("rst.in_ramp", 32'(bus.state), 32'd2);
    #2 reset = 1'b1;
    #1 chk_all("rst.async", 0, 0, M, 1, 0);
    #1 reset = 1'b0;
    tick(1);
    chk_all("rst.after", 0, 0, M, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/motor_sequencer.md
Name: motor_sequencer

Overview:
Start-up and supervision controller sitting between the encoder reader, the PI control loop and the PWM generator.
- Runs a fixed open-loop kick to get the rotor turning.
- Hands over to the closed loop with a soft ramp of the desired period down to the commanded target.
- Holds closed-loop operation and drops to a latched fault on failed start or stall.
- Owns the PWM duty source, the desired_period fed to the PI loop, and the PI loop's reset.

Parameters:
KICK_DUTY, 10'd512, open-loop PWM duty applied during KICK
KICK_CYCLES, 32'd5_000_000, clk cycles spent in KICK
START_PERIOD, 32'd200_000, encoder period (clk cycles) that must be beaten to leave KICK; also the initial ramp setpoint
RAMP_STEP, 32'd1_000, desired_period decrement per ramp tick
RAMP_INTERVAL, 32'd50_000, clk cycles between ramp ticks
STALL_PERIOD, 32'd1_000_000, measured period above this counts as stalled
STALL_CYCLES, 32'd10_000_000, consecutive stalled cycles before FAULT

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  level; request motor start
stop  input  1  level; request motor stop (priority over everything except reset)
clear_fault  input  1  level; leave FAULT
target_period  input  32  commanded encoder period, unsigned, clk cycles
period  input  32  measured encoder period from encoder reader, unsigned
loop_duty  input  10  PI loop duty output
duty_out  output  10  duty to PWM
desired_period  output  32  setpoint to PI loop
loop_reset  output  1  active-high reset to PI loop integrator (integrator ORs it with global reset)
state  output  3  IDLE=0, KICK=1, RAMP=2, RUN=3, FAULT=4
fault  output  1  high while in FAULT

Behaviour:
- Reset (async): state=IDLE, desired_period=32'h7FFF_FFFF, loop_reset=1, fault=0, duty_out=0, all timers cleared.
- state, desired_period and internal timers are registered.
- duty_out, loop_reset and fault are decoded from the registered state. duty_out is a combinational mux, so loop_duty passes through with zero latency in RAMP/RUN.
- Priority each cycle: stop > fault conditions > normal transitions.
- stop=1 in KICK/RAMP/RUN -> IDLE next edge. stop has no effect in IDLE/FAULT.
- IDLE: duty_out=0, loop_reset=1, desired_period=32'h7FFF_FFFF.
  - start=1 and stop=0 -> KICK; kick timer loads KICK_CYCLES-1.
- KICK: duty_out=KICK_DUTY, loop_reset=1; timer decrements each cycle, so exactly KICK_CYCLES cycles are spent in KICK.
  - On the cycle timer==0: if period < START_PERIOD -> RAMP, desired_period<=START_PERIOD, ramp timer loads RAMP_INTERVAL-1.
  - Otherwise -> FAULT (failed start).
- RAMP: duty_out=loop_duty, loop_reset=0; ramp timer decrements.
  - At 0 the timer reloads and desired_period <= max(desired_period-RAMP_STEP, target_period), as unsigned compare with no underflow.
  - If desired_period <= target_period is already true at a tick, desired_period<=target_period instead.
  - Enter RUN on the edge after desired_period == target_period is registered.
- RUN: duty_out=loop_duty, loop_reset=0; desired_period<=target_period every cycle, so target changes take effect with 1-cycle latency.
- Stall supervision (RAMP and RUN only):
  - The stall counter increments while period > STALL_PERIOD and clears to 0 on any cycle with period <= STALL_PERIOD, or outside RAMP/RUN.
  - Reaching STALL_CYCLES consecutive counts -> FAULT.
  - Counter saturates and never wraps.
- FAULT: duty_out=0, loop_reset=1, fault=1, desired_period=32'h7FFF_FFFF.
  - start is ignored; clear_fault=1 -> IDLE.
  - If start is still high after clear, a new KICK begins on the following edge.
- Simultaneous events:
  - stop with timer expiry -> IDLE.
  - stall-limit with ramp completion -> FAULT.
  - clear_fault with start in FAULT -> IDLE first.
- Reset asserted mid-operation returns immediately (async) to reset values; no stale timer or desired_period survives.

Test Plan:
Bench params: KICK_DUTY=300, KICK_CYCLES=16, START_PERIOD=1000, RAMP_STEP=100, RAMP_INTERVAL=4, STALL_PERIOD=5000, STALL_CYCLES=8.
- Normal start, target=600, period=800 held:
  - start pulse -> 16 cycles with duty_out=300, loop_reset=1, then RAMP.
  - desired_period 1000,900,800,700,600 at 4-cycle spacing, then state=3.
  - duty_out tracks loop_duty (e.g. 10'd123) same cycle.
- Clamp: target=650 -> ramp 1000,900,800,700,650 -> RUN. Target change to 620 in RUN -> desired_period=620 one cycle later.
- Failed start: period=2000 through KICK -> FAULT after 16 KICK cycles, fault=1, duty_out=0. start held is ignored; clear_fault -> IDLE.
- Stall in RUN:
  - period=6000 for 7 cycles, then 4000 for 1 cycle, then 6000 -> no fault until 8 further consecutive cycles.
  - After those 8 cycles -> FAULT.
- stop in KICK at cycle 5 with start still high -> IDLE next edge, duty_out=0.
- Reset asserted mid-RAMP (desired_period=800) -> immediately state=0, desired_period=32'h7FFF_FFFF, loop_reset=1.
